// File: rtl/sdram_req_arbiter_pkg.sv
// Shared types and constants for the CPU/DMA SDRAM request arbiter.
package oric_sdram_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CPU_BUSY = 2'd1,
      DMA_BUSY = 2'd2
   } state_t;

   localparam int BYTE_W = 8;
   localparam int WORD_W = 16;
   localparam int DS_W   = 2;

   localparam logic [DS_W-1:0] DS_READ = 2'b11;
   localparam logic [DS_W-1:0] DS_LO   = 2'b01;
   localparam logic [DS_W-1:0] DS_HI   = 2'b10;

   function automatic logic [DS_W-1:0] byte_sel(input logic we, input logic a0);
      if (!we)
         return DS_READ;
      return a0 ? DS_HI : DS_LO;
   endfunction

   function automatic logic [BYTE_W-1:0] lane_pick(input logic [WORD_W-1:0] q, input logic a0);
      return a0 ? q[15:8] : q[7:0];
   endfunction

endpackage

// File: rtl/sdram_req_arbiter_if.sv
// Bundle of CPU bus, DMA requester and toggle-handshake SDRAM port signals.
interface sdram_req_arbiter_if #(parameter int ADDR_W = 16);

   logic              cpu_cs, cpu_oe, cpu_we;
   logic [ADDR_W-1:0] cpu_a;
   logic [7:0]        cpu_d;
   logic [7:0]        cpu_q;

   logic              dma_req, dma_we;
   logic [ADDR_W-1:0] dma_a;
   logic [7:0]        dma_d;
   logic              dma_gnt, dma_done;
   logic [7:0]        dma_q;

   logic              port_req, port_ack;
   logic [ADDR_W-1:0] port_a;
   logic [1:0]        port_ds;
   logic              port_we;
   logic [15:0]       port_d;
   logic [15:0]       port_q;

   // arbiter side
   modport master (
      input  cpu_cs, cpu_oe, cpu_we, cpu_a, cpu_d,
      output cpu_q,
      input  dma_req, dma_we, dma_a, dma_d,
      output dma_gnt, dma_done, dma_q,
      output port_req, port_a, port_ds, port_we, port_d,
      input  port_ack, port_q
   );

   // CPU, DMA and SDRAM controller side
   modport slave (
      output cpu_cs, cpu_oe, cpu_we, cpu_a, cpu_d,
      input  cpu_q,
      output dma_req, dma_we, dma_a, dma_d,
      input  dma_gnt, dma_done, dma_q,
      input  port_req, port_a, port_ds, port_we, port_d,
      output port_ack, port_q
   );

endinterface

// File: rtl/sdram_req_arbiter_cpu_req_detect.sv
// Turns CPU strobe rises and read-address changes into a single-cycle event.
module cpu_req_detect
   import oric_sdram_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              cs,
   input  logic              oe,
   input  logic              we,
   input  logic [ADDR_W-1:0] a,
   input  logic [7:0]        d,
   output logic              evt,
   output logic [ADDR_W-1:0] cap_a,
   output logic [7:0]        cap_d,
   output logic              cap_we
);

   logic              rd, wr;
   logic              rd_q, wr_q;
   logic [ADDR_W-1:0] a_q;

   assign rd = cs & oe;
   assign wr = cs & we;

   // history tracks live inputs even in reset so release cannot look like an edge
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         rd_q <= rd;
         wr_q <= wr;
         a_q  <= a;
      end else begin
         rd_q <= rd;
         wr_q <= wr;
         a_q  <= a;
      end
   end

   assign evt    = (rd & ~rd_q) | (wr & ~wr_q) | (rd & (a != a_q));
   assign cap_a  = a;
   assign cap_d  = d;
   assign cap_we = we;

endmodule

// File: rtl/sdram_req_arbiter.sv
// Arbitrates a CPU pending slot and a DMA requester onto one toggle-handshake SDRAM port.
//   state    | meaning
//   IDLE     | no transaction outstanding, grant decision each cycle
//   CPU_BUSY | CPU access issued, waiting for port_ack == port_req
//   DMA_BUSY | DMA access issued, waiting for port_ack == port_req
module sdram_req_arbiter
   import oric_sdram_pkg::*;
#(
   parameter int ADDR_W       = 16,
   parameter int STARVE_LIMIT = 8
) (
   input  logic clk_sys,
   input  logic reset,
   sdram_req_arbiter_if.master bus
);

   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   logic              evt, evt_we;
   logic [ADDR_W-1:0] evt_a;
   logic [7:0]        evt_d;

   state_t              state;
   logic                cpu_pend, pend_we;
   logic [ADDR_W-1:0]   pend_a;
   logic [7:0]          pend_d;
   logic [STARVE_W-1:0] starve_cnt;

   logic              port_req_r, port_we_r, dma_gnt_r, dma_done_r;
   logic [ADDR_W-1:0] port_a_r;
   logic [1:0]        port_ds_r;
   logic [15:0]       port_d_r;
   logic [7:0]        cpu_q_r, dma_q_r;

   logic done, grant_dma, grant_cpu;

   cpu_req_detect #(.ADDR_W(ADDR_W)) u_detect (
      .clk_sys (clk_sys),
      .reset   (reset),
      .cs      (bus.cpu_cs),
      .oe      (bus.cpu_oe),
      .we      (bus.cpu_we),
      .a       (bus.cpu_a),
      .d       (bus.cpu_d),
      .evt     (evt),
      .cap_a   (evt_a),
      .cap_d   (evt_d),
      .cap_we  (evt_we)
   );

   assign done      = (state != IDLE) && (bus.port_ack == port_req_r);
   assign grant_dma = (state == IDLE) && bus.dma_req && (!cpu_pend || starve_cnt == STARVE_MAX);
   assign grant_cpu = (state == IDLE) && cpu_pend && !grant_dma;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state      <= IDLE;
         cpu_pend   <= 1'b0;
         pend_a     <= '0;
         pend_d     <= '0;
         pend_we    <= 1'b0;
         starve_cnt <= '0;
         dma_gnt_r  <= 1'b0;
         dma_done_r <= 1'b0;
         cpu_q_r    <= 8'h00;
         dma_q_r    <= 8'h00;
         port_a_r   <= '0;
         port_ds_r  <= DS_READ;
         port_we_r  <= 1'b0;
         port_d_r   <= '0;
         port_req_r <= bus.port_ack;
      end else begin
         dma_gnt_r  <= 1'b0;
         dma_done_r <= 1'b0;

         // a fresh capture wins over the clear from a same-cycle CPU grant
         if (evt) begin
            cpu_pend <= 1'b1;
            pend_a   <= evt_a;
            pend_d   <= evt_d;
            pend_we  <= evt_we;
         end else if (grant_cpu) begin
            cpu_pend <= 1'b0;
         end

         if (!bus.dma_req || grant_dma)
            starve_cnt <= '0;
         else if (grant_cpu && starve_cnt != STARVE_MAX)
            starve_cnt <= starve_cnt + STARVE_W'(1);

         case (state)
            IDLE: begin
               if (grant_dma) begin
                  state      <= DMA_BUSY;
                  port_req_r <= ~port_req_r;
                  port_a_r   <= bus.dma_a;
                  port_we_r  <= bus.dma_we;
                  port_ds_r  <= byte_sel(bus.dma_we, bus.dma_a[0]);
                  port_d_r   <= {bus.dma_d, bus.dma_d};
                  dma_gnt_r  <= 1'b1;
               end else if (grant_cpu) begin
                  state      <= CPU_BUSY;
                  port_req_r <= ~port_req_r;
                  port_a_r   <= pend_a;
                  port_we_r  <= pend_we;
                  port_ds_r  <= byte_sel(pend_we, pend_a[0]);
                  port_d_r   <= {pend_d, pend_d};
               end
            end
            CPU_BUSY: begin
               if (done) begin
                  state <= IDLE;
                  if (!port_we_r)
                     cpu_q_r <= lane_pick(bus.port_q, port_a_r[0]);
               end
            end
            DMA_BUSY: begin
               if (done) begin
                  state      <= IDLE;
                  dma_done_r <= 1'b1;
                  if (!port_we_r)
                     dma_q_r <= lane_pick(bus.port_q, port_a_r[0]);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.port_req = port_req_r;
   assign bus.port_a   = port_a_r;
   assign bus.port_ds  = port_ds_r;
   assign bus.port_we  = port_we_r;
   assign bus.port_d   = port_d_r;
   assign bus.dma_gnt  = dma_gnt_r;
   assign bus.dma_done = dma_done_r;
   assign bus.cpu_q    = cpu_q_r;
   assign bus.dma_q    = dma_q_r;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Directed scenario bench for sdram_req_arbiter with hand-computed expectations.
module tb_sdram_req_arbiter;
   import oric_sdram_pkg::*;

   logic clk_sys = 1'b0;
   logic reset   = 1'b1;
   int   checks  = 0;
   int   errors  = 0;

   sdram_req_arbiter_if #(.ADDR_W(16)) bus ();

   sdram_req_arbiter #(.ADDR_W(16), .STARVE_LIMIT(8)) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .bus     (bus)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic drain();
      bus.cpu_cs = 1'b0; bus.cpu_oe = 1'b0; bus.cpu_we = 1'b0; bus.dma_req = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_sys);
         if (bus.port_ack !== bus.port_req) bus.port_ack = bus.port_req;
      end
   endtask

   task automatic test_reset();
      bus.cpu_cs = 1'b1; bus.cpu_oe = 1'b1; bus.cpu_a = 16'h0042;
      repeat (2) @(negedge clk_sys);
      checks++; if (bus.port_req !== 1'b1) begin errors++; $display("FAIL rst_port_req got %b want 1", bus.port_req); end
      checks++; if (bus.port_ds !== 2'b11) begin errors++; $display("FAIL rst_port_ds got %b want 11", bus.port_ds); end
      checks++; if (bus.cpu_q !== 8'h00) begin errors++; $display("FAIL rst_cpu_q got %h want 00", bus.cpu_q); end
      checks++; if (bus.dma_q !== 8'h00) begin errors++; $display("FAIL rst_dma_q got %h want 00", bus.dma_q); end
      checks++; if ({bus.dma_gnt, bus.dma_done, bus.port_we} !== 3'b000) begin errors++; $display("FAIL rst_pulses got %b want 000", {bus.dma_gnt, bus.dma_done, bus.port_we}); end
      checks++; if ({bus.port_a, bus.port_d} !== 32'h0) begin errors++; $display("FAIL rst_port_a_d got %h want 0", {bus.port_a, bus.port_d}); end
      checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL rst_state got %0d want IDLE", dut.state); end
      reset = 1'b0;
      repeat (3) @(negedge clk_sys);
      checks++; if (bus.port_req !== 1'b1) begin errors++; $display("FAIL rst_no_event got port_req %b want 1", bus.port_req); end
      checks++; if (dut.cpu_pend !== 1'b0) begin errors++; $display("FAIL rst_no_pend got %b want 0", dut.cpu_pend); end
      bus.cpu_cs = 1'b0; bus.cpu_oe = 1'b0;
      @(negedge clk_sys);
   endtask

   task automatic test_cpu_read();
      logic req0;
      req0 = bus.port_req;
      bus.cpu_cs = 1'b1; bus.cpu_oe = 1'b1; bus.cpu_we = 1'b0; bus.cpu_a = 16'h1235;
      @(negedge clk_sys);
      checks++; if (bus.port_req !== req0) begin errors++; $display("FAIL rd_early_toggle got %b want %b", bus.port_req, req0); end
      @(negedge clk_sys);
      checks++; if (bus.port_req !== ~req0) begin errors++; $display("FAIL rd_toggle got %b want %b", bus.port_req, ~req0); end
      checks++; if (bus.port_ds !== 2'b11) begin errors++; $display("FAIL rd_ds got %b want 11", bus.port_ds); end
      checks++; if (bus.port_a !== 16'h1235) begin errors++; $display("FAIL rd_addr got %h want 1235", bus.port_a); end
      checks++; if (bus.cpu_q !== 8'h00) begin errors++; $display("FAIL rd_q_before got %h want 00", bus.cpu_q); end
      bus.port_q = 16'hAB12; bus.port_ack = bus.port_req;
      @(negedge clk_sys);
      checks++; if (bus.cpu_q !== 8'hAB) begin errors++; $display("FAIL rd_cpu_q got %h want ab", bus.cpu_q); end
      bus.cpu_cs = 1'b0; bus.cpu_oe = 1'b0;
      @(negedge clk_sys);
   endtask

   task automatic test_cpu_write();
      logic req0;
      req0 = bus.port_req;
      bus.cpu_cs = 1'b1; bus.cpu_we = 1'b1; bus.cpu_a = 16'h0400; bus.cpu_d = 8'h5A;
      repeat (2) @(negedge clk_sys);
      checks++; if (bus.port_req !== ~req0) begin errors++; $display("FAIL wr_toggle got %b want %b", bus.port_req, ~req0); end
      checks++; if (bus.port_we !== 1'b1) begin errors++; $display("FAIL wr_we got %b want 1", bus.port_we); end
      checks++; if (bus.port_ds !== 2'b01) begin errors++; $display("FAIL wr_ds_even got %b want 01", bus.port_ds); end
      checks++; if (bus.port_d !== 16'h5A5A) begin errors++; $display("FAIL wr_data got %h want 5a5a", bus.port_d); end
      bus.port_q = 16'hFFFF; bus.port_ack = bus.port_req;
      @(negedge clk_sys);
      checks++; if (bus.cpu_q !== 8'hAB) begin errors++; $display("FAIL wr_cpu_q_kept got %h want ab", bus.cpu_q); end
      bus.cpu_cs = 1'b0; bus.cpu_we = 1'b0;
      @(negedge clk_sys);
      bus.cpu_cs = 1'b1; bus.cpu_we = 1'b1; bus.cpu_a = 16'h0401; bus.cpu_d = 8'hC7;
      repeat (2) @(negedge clk_sys);
      checks++; if (bus.port_ds !== 2'b10) begin errors++; $display("FAIL wr_ds_odd got %b want 10", bus.port_ds); end
      checks++; if (bus.port_d !== 16'hC7C7) begin errors++; $display("FAIL wr_data_odd got %h want c7c7", bus.port_d); end
      bus.port_ack = bus.port_req;
      @(negedge clk_sys);
      bus.cpu_cs = 1'b0; bus.cpu_we = 1'b0;
      @(negedge clk_sys);
   endtask

   task automatic test_cpu_then_dma();
      logic req0;
      req0 = bus.port_req;
      bus.cpu_cs = 1'b1; bus.cpu_oe = 1'b1; bus.cpu_a = 16'h0300;
      @(negedge clk_sys);
      bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_a = 16'h0500; bus.dma_d = 8'h77;
      @(negedge clk_sys);
      checks++; if (bus.port_a !== 16'h0300 || bus.dma_gnt !== 1'b0) begin errors++; $display("FAIL sim_cpu_first got a=%h gnt=%b want a=0300 gnt=0", bus.port_a, bus.dma_gnt); end
      bus.port_q = 16'h0099; bus.port_ack = bus.port_req;
      @(negedge clk_sys);
      checks++; if (bus.cpu_q !== 8'h99) begin errors++; $display("FAIL sim_cpu_q got %h want 99", bus.cpu_q); end
      bus.cpu_cs = 1'b0; bus.cpu_oe = 1'b0;
      @(negedge clk_sys);
      checks++; if (bus.dma_gnt !== 1'b1) begin errors++; $display("FAIL sim_dma_gnt got %b want 1", bus.dma_gnt); end
      checks++; if (bus.port_a !== 16'h0500 || bus.port_d !== 16'h7777) begin errors++; $display("FAIL sim_dma_port got a=%h d=%h want 0500 7777", bus.port_a, bus.port_d); end
      checks++; if (bus.port_ds !== 2'b01 || bus.port_req !== req0) begin errors++; $display("FAIL sim_dma_ds_req got ds=%b req=%b want 01 %b", bus.port_ds, bus.port_req, req0); end
      bus.dma_req = 1'b0;
      bus.port_q = 16'h1234; bus.port_ack = bus.port_req;
      @(negedge clk_sys);
      checks++; if (bus.dma_done !== 1'b1) begin errors++; $display("FAIL sim_dma_done got %b want 1", bus.dma_done); end
      checks++; if (bus.dma_q !== 8'h00) begin errors++; $display("FAIL sim_dma_q_kept got %h want 00", bus.dma_q); end
      @(negedge clk_sys);
      checks++; if (bus.dma_done !== 1'b0) begin errors++; $display("FAIL sim_done_width got %b want 0", bus.dma_done); end
   endtask

   task automatic test_starvation();
      int   issues = 0, cpu_grants = 0, dma_at = -1, wait_cnt = 0;
      int   starve_at8 = -1, starve_after = -1;
      logic prev_req;
      bus.cpu_cs = 1'b1; bus.cpu_oe = 1'b1; bus.cpu_we = 1'b0; bus.cpu_a = 16'h0100;
      bus.port_q = 16'h0000;
      @(negedge clk_sys);
      bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_a = 16'h0600;
      prev_req = bus.port_req;
      for (int cyc = 0; cyc < 300 && issues < 9; cyc++) begin
         @(negedge clk_sys);
         if (bus.port_req !== prev_req) begin
            prev_req = bus.port_req;
            issues++;
            if (bus.dma_gnt === 1'b1) begin
               dma_at = issues; starve_after = int'(dut.starve_cnt); bus.dma_req = 1'b0;
            end else begin
               cpu_grants++;
               if (cpu_grants == 8) starve_at8 = int'(dut.starve_cnt);
            end
         end
         bus.cpu_a = bus.cpu_a + 16'h1;
         if (bus.port_ack !== bus.port_req) begin
            wait_cnt++;
            if (wait_cnt >= 2) begin bus.port_ack = bus.port_req; wait_cnt = 0; end
         end
      end
      checks++; if (issues != 9) begin errors++; $display("FAIL stv_timeout got %0d issues want 9", issues); end
      checks++; if (cpu_grants != 8) begin errors++; $display("FAIL stv_cpu_grants got %0d want 8", cpu_grants); end
      checks++; if (dma_at != 9) begin errors++; $display("FAIL stv_dma_slot got %0d want 9", dma_at); end
      checks++; if (starve_at8 != 8) begin errors++; $display("FAIL stv_cnt_sat got %0d want 8", starve_at8); end
      checks++; if (starve_after != 0) begin errors++; $display("FAIL stv_cnt_clear got %0d want 0", starve_after); end
      drain();
   endtask

   task automatic test_overwrite_in_dma();
      int   dones = 0, issues = 0;
      logic found = 1'b0;
      logic prev_req;
      logic [15:0] last_a = 16'hFFFF;
      bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_a = 16'h2001;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk_sys);
         if (bus.dma_gnt === 1'b1) found = 1'b1;
      end
      bus.dma_req = 1'b0;
      checks++; if (found !== 1'b1) begin errors++; $display("FAIL ovw_dma_gnt got %b want 1", found); end
      bus.cpu_cs = 1'b1; bus.cpu_oe = 1'b1; bus.cpu_we = 1'b0; bus.cpu_a = 16'h0010;
      @(negedge clk_sys);
      bus.cpu_a = 16'h0020;
      repeat (2) @(negedge clk_sys);
      prev_req = bus.port_req;
      bus.port_q = 16'hC33C; bus.port_ack = bus.port_req;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk_sys);
         if (bus.dma_done === 1'b1) dones++;
         if (bus.port_req !== prev_req) begin
            prev_req = bus.port_req; issues++; last_a = bus.port_a;
            bus.port_q = 16'h5566; bus.port_ack = bus.port_req;
         end
      end
      checks++; if (dones != 1) begin errors++; $display("FAIL ovw_done_count got %0d want 1", dones); end
      checks++; if (issues != 1) begin errors++; $display("FAIL ovw_issue_count got %0d want 1", issues); end
      checks++; if (last_a !== 16'h0020) begin errors++; $display("FAIL ovw_addr got %h want 0020", last_a); end
      checks++; if (bus.dma_q !== 8'hC3) begin errors++; $display("FAIL ovw_dma_q got %h want c3", bus.dma_q); end
      checks++; if (bus.cpu_q !== 8'h66) begin errors++; $display("FAIL ovw_cpu_q got %h want 66", bus.cpu_q); end
      bus.cpu_cs = 1'b0; bus.cpu_oe = 1'b0;
      @(negedge clk_sys);
   endtask

   task automatic test_reset_in_busy();
      logic req0, req_after;
      int   dones = 0;
      req0 = bus.port_req;
      bus.cpu_cs = 1'b1; bus.cpu_oe = 1'b1; bus.cpu_we = 1'b0; bus.cpu_a = 16'h0777;
      repeat (2) @(negedge clk_sys);
      checks++; if (dut.state !== CPU_BUSY) begin errors++; $display("FAIL rb_busy got %0d want CPU_BUSY", dut.state); end
      reset = 1'b1;
      @(negedge clk_sys);
      reset = 1'b0; bus.cpu_cs = 1'b0; bus.cpu_oe = 1'b0;
      req_after = bus.port_req;
      checks++; if (req_after !== req0) begin errors++; $display("FAIL rb_req_resync got %b want %b", req_after, req0); end
      repeat (3) @(negedge clk_sys);
      bus.port_q = 16'hEEEE; bus.port_ack = ~bus.port_ack;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_sys);
         if (bus.dma_done === 1'b1) dones++;
      end
      checks++; if (bus.port_req !== req_after) begin errors++; $display("FAIL rb_req_stable got %b want %b", bus.port_req, req_after); end
      checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL rb_state got %0d want IDLE", dut.state); end
      checks++; if (bus.cpu_q !== 8'h00) begin errors++; $display("FAIL rb_cpu_q got %h want 00", bus.cpu_q); end
      checks++; if (dones != 0) begin errors++; $display("FAIL rb_no_done got %0d want 0", dones); end
      reset = 1'b1;
      @(negedge clk_sys);
      reset = 1'b0;
      @(negedge clk_sys);
   endtask

   initial begin
      bus.cpu_cs = 1'b0; bus.cpu_oe = 1'b0; bus.cpu_we = 1'b0;
      bus.cpu_a = 16'h0; bus.cpu_d = 8'h0;
      bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_a = 16'h0; bus.dma_d = 8'h0;
      bus.port_ack = 1'b1; bus.port_q = 16'h0;
      test_reset();
      test_cpu_read();
      test_cpu_write();
      test_cpu_then_dma();
      test_starvation();
      test_overwrite_in_dma();
      test_reset_in_busy();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sdram_req_arbiter.md
SDRAM_REQ_ARBITER -- requirements
Module: sdram_req_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 16, width of the byte address on all ports.
REQ-002 Parameter: STARVE_LIMIT, default 8, count of consecutive CPU grants after which a waiting DMA request wins.
REQ-003 Port: clk_sys  in  1  system clock; all logic is on its rising edge.
REQ-004 Port: reset  in  1  reset; it is synchronous and active-high.
REQ-005 Ports: cpu_cs, cpu_oe, cpu_we  in  1 each  CPU bus select, read strobe and write strobe.
REQ-006 Ports: cpu_a in ADDR_W; cpu_d in 8; cpu_q out 8.
- cpu_a is the CPU byte address.
- cpu_d is the CPU write data.
- cpu_q is the registered CPU read data.
REQ-007 Ports: dma_req in 1; dma_we in 1; dma_a in ADDR_W; dma_d in 8.
- dma_req is the DMA requester's request; it is held high until accepted.
REQ-008 Ports: dma_gnt out 1; dma_done out 1; dma_q out 8.
- dma_gnt is a one-cycle accept pulse.
- dma_done is a one-cycle completion pulse.
- dma_q is the DMA read data, valid when dma_done is high.
REQ-009 Ports: port_req out 1 (toggle request); port_ack in 1 (toggle acknowledge).
REQ-010 Ports: port_a out ADDR_W; port_ds out 2; port_we out 1; port_d out 16; port_q in 16.
- port_ds is the byte-lane select.
- port_q is the SDRAM read data.

Function
REQ-011 A CPU event is any one of the following:
- rising edge of cpu_cs&cpu_oe;
- rising edge of cpu_cs&cpu_we;
- cpu_a differing from its previous-cycle value while cpu_cs&cpu_oe is high.
REQ-012 A CPU event captures cpu_a, cpu_d and cpu_we into a one-deep pending slot and sets cpu_pend.
REQ-013 A CPU event while cpu_pend is already set overwrites the slot; the latest event wins and nothing is queued.
REQ-014 State machine states: IDLE, CPU_BUSY, DMA_BUSY.
REQ-015 In IDLE, cpu_pend has priority over dma_req, except when starve_cnt equals STARVE_LIMIT and dma_req is high; then the DMA request is granted.
REQ-016 Issue takes exactly one cycle after the decision:
- port_req toggles;
- port_a, port_we, port_ds and port_d load from the granted requester;
- the state moves to CPU_BUSY or DMA_BUSY.
REQ-017 A CPU grant clears cpu_pend in the same cycle. A CPU event arriving in that same cycle re-sets cpu_pend with the new capture.
REQ-018 A DMA grant pulses dma_gnt for one cycle, in the issue cycle.
REQ-019 port_ds is 2'b11 for reads. For writes it is 2'b10 when the address bit 0 is 1, else 2'b01.
REQ-020 port_d is {d,d} of the granted requester.
REQ-021 Completion is the first cycle in which port_ack equals port_req while in a BUSY state. The state returns to IDLE on the next edge.
REQ-022 On completion of a read, the selected byte is registered into cpu_q or dma_q in the completion cycle. The byte is port_q[15:8] when address bit 0 is 1, else port_q[7:0].
REQ-023 On completion of a write, cpu_q and dma_q are unchanged.
REQ-024 dma_done pulses for one cycle at the completion of every DMA transaction.
REQ-025 starve_cnt (width clog2(STARVE_LIMIT+1)) increments, saturating, on each CPU grant made while dma_req is high. It clears on each DMA grant and whenever dma_req is low.
REQ-026 Minimum latency from a CPU event to port_req toggling is 2 cycles (capture, then issue) from IDLE.
REQ-027 port_ack is sampled only in BUSY states. An ack toggle seen in IDLE is ignored.
REQ-028 Port outputs are held stable from issue until completion.

Reset
REQ-029 Reset forces:
- state IDLE;
- cpu_pend 0 and starve_cnt 0;
- dma_gnt 0 and dma_done 0;
- cpu_q 8'h00 and dma_q 8'h00;
- port_a 0, port_ds 2'b11, port_we 0, port_d 0.
REQ-030 Reset loads port_req with the current port_ack value, so no transaction appears outstanding.
REQ-031 Reset during a BUSY state abandons the transaction. No done pulse is generated, and the late ack is ignored per REQ-027.
REQ-032 The edge-detect history registers load the current strobe and address values on reset, so no CPU event fires in the first cycle after reset.

Structure
REQ-033 Package oric_sdram_pkg holds:
- the state enum (IDLE/CPU_BUSY/DMA_BUSY);
- the DS_READ, DS_LO and DS_HI constants;
- the byte-select helper constant widths.
REQ-034 CPU event detection (REQ-011) is the sub-module cpu_req_detect. It outputs a one-cycle event pulse plus the captured a/d/we.

Verification
REQ-035 CPU read at cpu_a=16'h1235, acked with port_q=16'hAB12:
- port_req toggles 2 cycles after the strobe;
- port_ds=2'b11;
- cpu_q=8'hAB one cycle after the ack.
REQ-036 CPU write cpu_a=16'h0400, cpu_d=8'h5A:
- port_we=1, port_ds=2'b01, port_d=16'h5A5A;
- cpu_q is unchanged after the ack.
REQ-037 dma_req held high and a CPU event every cycle:
- 8 CPU grants occur;
- the 9th grant goes to DMA (dma_gnt pulse);
- starve_cnt returns to 0.
REQ-038 Two CPU events (addresses 16'h0010, then 16'h0020) while in DMA_BUSY:
- only 16'h0020 is issued after DMA completion;
- dma_done pulses once.
REQ-039 Reset asserted in CPU_BUSY, with port_ack toggled 3 cycles after reset is released:
- no state change;
- port_req does not toggle;
- cpu_q stays 8'h00.
REQ-040 Simultaneous CPU event and dma_req in IDLE with starve_cnt=0: the CPU is granted first, and DMA is granted immediately after CPU completion.
